// File: rtl/e15_prog_loader.sv
// e15_prog_loader: serial MSB-first loader for the E15 program memory.
// Assembles instruction words from a bitstream and writes them into the memory.
// Pads short programs with 12'h000, then releases the processor via cpu_run.
module e15_prog_loader #(
  parameter int unsigned WORD_W = 12,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         load_start,
  input  logic                         ser_valid,
  input  logic                         ser_data,
  input  logic                         load_end,
  input  logic [$clog2(DEPTH)-1:0]     pc,
  output logic [WORD_W-1:0]            instr,
  output logic                         cpu_run,
  output logic                         load_done,
  output logic                         load_err,
  output logic [$clog2(DEPTH+1)-1:0]   word_count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned BC_W   = $clog2(WORD_W);
  localparam int unsigned SHIFT_W = WORD_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_RUN,
    ST_ERR
  } state_e;

  state_e               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]     wc_q, wc_d;
  logic                 cpu_run_q, cpu_run_d;
  logic                 load_done_q, load_done_d;
  logic                 load_err_q, load_err_d;

  logic                 we_c;
  logic [AW-1:0]        waddr_c;
  logic [WORD_W-1:0]    wdata_c;

  logic [WORD_W-1:0]    mem_q [DEPTH];

  // Next-state, counter and memory-write decode.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    wc_d        = wc_q;
    cpu_run_d   = cpu_run_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;
    we_c        = 1'b0;
    waddr_c     = wc_q[AW-1:0];
    wdata_c     = '0;

    unique case (state_q)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          bit_cnt_d  = '0;
          wc_d       = '0;
          load_err_d = 1'b0;
          cpu_run_d  = 1'b0;
        end
      end

      ST_LOAD: begin
        if (load_end) begin
          // The bit presented alongside load_end is dropped.
          if (bit_cnt_q == '0) begin
            if (wc_q == CNT_W'(DEPTH)) begin
              state_d     = ST_RUN;
              cpu_run_d   = 1'b1;
              load_done_d = 1'b1;
            end else begin
              state_d = ST_FILL;
            end
          end else begin
            state_d    = ST_ERR;
            load_err_d = 1'b1;
            cpu_run_d  = 1'b0;
          end
        end else if (ser_valid) begin
          shift_d = {shift_q[SHIFT_W-2:0], ser_data};
          if (bit_cnt_q == BC_W'(WORD_W - 1)) begin
            we_c      = 1'b1;
            wdata_c   = {shift_q, ser_data};
            wc_d      = wc_q + CNT_W'(1);
            bit_cnt_d = '0;
            if (wc_q == CNT_W'(DEPTH - 1)) begin
              state_d     = ST_RUN;
              cpu_run_d   = 1'b1;
              load_done_d = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BC_W'(1);
          end
        end
      end

      ST_FILL: begin
        // Pad one entry per cycle with jmp 0 until the memory is full.
        we_c    = 1'b1;
        wdata_c = '0;
        wc_d    = wc_q + CNT_W'(1);
        if (wc_q == CNT_W'(DEPTH - 1)) begin
          state_d     = ST_RUN;
          cpu_run_d   = 1'b1;
          load_done_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      wc_q        <= '0;
      cpu_run_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      wc_q        <= wc_d;
      cpu_run_q   <= cpu_run_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
    end
  end

  // Program memory: zeroed by reset, single write port, async read by pc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_c) begin
      mem_q[waddr_c] <= wdata_c;
    end
  end

  assign instr      = mem_q[pc];
  assign cpu_run    = cpu_run_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = wc_q;

endmodule
